// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store front end for the word-wide data_memory RAM.
// Loads RD->CAP->DONE, sb/sh RD->WR->DONE, sw WR->DONE, rejects go straight to DONE; req is only sampled in IDLE.
module load_store_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h10001000,
  parameter int          DEPTH_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS) - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        fault_q, fault_d;

  logic        op_legal;
  logic        op_aligned;
  logic        in_window;
  logic        req_ok;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;
  logic [31:0] merged_word;

  // Request checks look at the live inputs, since they decide the state taken on the accepting edge.
  always_comb begin
    op_legal = 1'b0;
    case (op)
      4'b0000, 4'b0001, 4'b0010,
      4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010: op_legal = 1'b1;
      default:                   op_legal = 1'b0;
    endcase
  end

  always_comb begin
    op_aligned = 1'b1;
    case (op[1:0])
      2'b01:   op_aligned = (address[0] == 1'b0);
      2'b10:   op_aligned = (address[1:0] == 2'b00);
      default: op_aligned = 1'b1;
    endcase
  end

  assign in_window = (address >= BASE_ADDR) && (address <= LAST_ADDR);
  assign req_ok    = op_legal && op_aligned && in_window;

  // Lane extraction from the word returned by the RAM.
  always_comb begin
    sel_byte = mem_read_data[7:0];
    case (addr_q[1:0])
      2'b00:   sel_byte = mem_read_data[7:0];
      2'b01:   sel_byte = mem_read_data[15:8];
      2'b10:   sel_byte = mem_read_data[23:16];
      default: sel_byte = mem_read_data[31:24];
    endcase
    sel_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
  end

  // op[2] marks the unsigned variants.
  always_comb begin
    load_ext = mem_read_data;
    case (op_q[1:0])
      2'b00:   load_ext = {{24{sel_byte[7] & ~op_q[2]}}, sel_byte};
      2'b01:   load_ext = {{16{sel_half[15] & ~op_q[2]}}, sel_half};
      default: load_ext = mem_read_data;
    endcase
  end

  always_comb begin
    merged_word = mem_read_data;
    case (op_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'b00:   merged_word[7:0]   = sdata_q[7:0];
          2'b01:   merged_word[15:8]  = sdata_q[7:0];
          2'b10:   merged_word[23:16] = sdata_q[7:0];
          default: merged_word[31:24] = sdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged_word[31:16] = sdata_q[15:0];
        else           merged_word[15:0]  = sdata_q[15:0];
      end
      default: merged_word = sdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    load_data_d = load_data_q;
    fault_d     = fault_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = op;
          addr_d  = address;
          sdata_d = store_data;
          fault_d = ~req_ok;
          if (!req_ok)                              state_d = S_DONE;
          else if (op[3] && (op[1:0] == 2'b10))     state_d = S_WR;
          else                                      state_d = S_RD;
        end
      end
      S_RD:    state_d = op_q[3] ? S_WR : S_CAP;
      S_CAP: begin
        load_data_d = load_ext;
        state_d     = S_DONE;
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 4'b0000;
      addr_q      <= 32'h0;
      sdata_q     <= 32'h0;
      load_data_q <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
    end
  end

  // Strobes decode straight from the state register, so reset kills a write before the next edge.
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign fault          = done & fault_q;
  assign mem_read       = (state_q == S_RD);
  assign mem_write      = (state_q == S_WR);
  assign mem_address    = {addr_q[31:2], 2'b00};
  assign mem_write_data = mem_write ? merged_word : 32'h0;
  assign load_data      = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table through a scoreboard queue, plus reset-in-WR and held-req sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [3:0]  op;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        busy, done, fault;
  logic [31:0] load_data, mem_address, mem_write_data;
  logic        mem_read, mem_write;
  logic [31:0] mem_read_data;

  int tests = 0;
  int fails = 0;

  load_store_unit #(.BASE_ADDR(32'h10001000), .DEPTH_WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .address(address),
    .store_data(store_data), .busy(busy), .done(done), .fault(fault),
    .load_data(load_data), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, write on the strobe edge, preloaded while init is high.
  logic [31:0] ram [16];
  logic        init;
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
      ram[4]        <= 32'h12345678;
      ram[15]       <= 32'hA5A55A5A;
      mem_read_data <= 32'h0;
    end else begin
      if (mem_read)  mem_read_data        <= ram[mem_address[5:2]];
      if (mem_write) ram[mem_address[5:2]] <= mem_write_data;
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic        flt;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] ld;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [23];
  vec_t exp_q [$];

  function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] s,
                              input logic f, input int l, input int r, input int w,
                              input logic [31:0] ld, input logic [31:0] wd);
    vec_t v;
    v.op = o; v.addr = a; v.sd = s; v.flt = f; v.lat = l; v.nrd = r; v.nwr = w; v.ld = ld; v.wd = wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_done"},  32'(done), 32'h0);
    check({tag, "_fault"}, 32'(fault), 32'h0);
    check({tag, "_rd"},    32'(mem_read), 32'h0);
    check({tag, "_wr"},    32'(mem_write), 32'h0);
    check({tag, "_ld"},    load_data, 32'h0);
    check({tag, "_wd"},    mem_write_data, 32'h0);
    check({tag, "_ma"},    mem_address, 32'h0);
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_txn(input vec_t v);
    vec_t        e;
    int          nrd = 0, nwr = 0, nbusy = 0, lat = -1;
    logic [31:0] wd = 32'h0;
    logic        flt = 1'b0;
    exp_q.push_back(v);
    req = 1'b1; op = v.op; address = v.addr; store_data = v.sd;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (busy) nbusy++;
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; wd = mem_write_data; end
      if (mem_read && mem_write) check("strobe_excl", 32'h1, 32'h0);
      if (mem_read || mem_write) check("mem_addr", mem_address, {v.addr[31:2], 2'b00});
      if (done) begin lat = c; flt = fault; break; end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    if (lat < 0) begin
      check("done_timeout", 32'h0, 32'h1);
    end else begin
      check("latency", 32'(lat), 32'(e.lat));
      check("fault", 32'(flt), 32'(e.flt));
      check("busy_cycles", 32'(nbusy), 32'(e.lat + 1));
      check("read_count", 32'(nrd), 32'(e.nrd));
      check("write_count", 32'(nwr), 32'(e.nwr));
      check("load_data", load_data, e.ld);
      if (e.nwr > 0) check("write_data", wd, e.wd);
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(4'b0010, 32'h10001010, 32'h0,        1'b0, 2, 1, 0, 32'h12345678, 32'h0);
    vecs[1]  = mk(4'b0001, 32'h10001012, 32'h0,        1'b0, 2, 1, 0, 32'h00001234, 32'h0);
    vecs[2]  = mk(4'b0100, 32'h10001013, 32'h0,        1'b0, 2, 1, 0, 32'h00000012, 32'h0);
    vecs[3]  = mk(4'b0000, 32'h10001010, 32'h0,        1'b0, 2, 1, 0, 32'h00000078, 32'h0);
    vecs[4]  = mk(4'b1000, 32'h10001011, 32'h000000AB, 1'b0, 2, 1, 1, 32'h00000078, 32'h1234AB78);
    vecs[5]  = mk(4'b0000, 32'h10001011, 32'h0,        1'b0, 2, 1, 0, 32'hFFFFFFAB, 32'h0);
    vecs[6]  = mk(4'b0100, 32'h10001011, 32'h0,        1'b0, 2, 1, 0, 32'h000000AB, 32'h0);
    vecs[7]  = mk(4'b0001, 32'h10001010, 32'h0,        1'b0, 2, 1, 0, 32'hFFFFAB78, 32'h0);
    vecs[8]  = mk(4'b0101, 32'h10001010, 32'h0,        1'b0, 2, 1, 0, 32'h0000AB78, 32'h0);
    vecs[9]  = mk(4'b1001, 32'h10001012, 32'h00008001, 1'b0, 2, 1, 1, 32'h0000AB78, 32'h8001AB78);
    vecs[10] = mk(4'b0001, 32'h10001012, 32'h0,        1'b0, 2, 1, 0, 32'hFFFF8001, 32'h0);
    vecs[11] = mk(4'b1001, 32'h10001001, 32'h0000BEEF, 1'b1, 0, 0, 0, 32'hFFFF8001, 32'h0);
    vecs[12] = mk(4'b0010, 32'h10001040, 32'h0,        1'b1, 0, 0, 0, 32'hFFFF8001, 32'h0);
    vecs[13] = mk(4'b0011, 32'h10001010, 32'h0,        1'b1, 0, 0, 0, 32'hFFFF8001, 32'h0);
    vecs[14] = mk(4'b0010, 32'h10000FFC, 32'h0,        1'b1, 0, 0, 0, 32'hFFFF8001, 32'h0);
    vecs[15] = mk(4'b0010, 32'h1000103C, 32'h0,        1'b0, 2, 1, 0, 32'hA5A55A5A, 32'h0);
    vecs[16] = mk(4'b1010, 32'h10001000, 32'hDEADBEEF, 1'b0, 1, 0, 1, 32'hA5A55A5A, 32'hDEADBEEF);
    vecs[17] = mk(4'b0000, 32'h10001003, 32'h0,        1'b0, 2, 1, 0, 32'hFFFFFFDE, 32'h0);
    vecs[18] = mk(4'b1011, 32'h10001000, 32'h0,        1'b1, 0, 0, 0, 32'hFFFFFFDE, 32'h0);
    vecs[19] = mk(4'b0101, 32'h10001003, 32'h0,        1'b1, 0, 0, 0, 32'hFFFFFFDE, 32'h0);
    vecs[20] = mk(4'b1010, 32'h10001002, 32'h0,        1'b1, 0, 0, 0, 32'hFFFFFFDE, 32'h0);
    vecs[21] = mk(4'b1000, 32'h1000103F, 32'h123456C3, 1'b0, 2, 1, 1, 32'hFFFFFFDE, 32'hC3A55A5A);
    vecs[22] = mk(4'b0010, 32'h1000103C, 32'h0,        1'b0, 2, 1, 0, 32'hC3A55A5A, 32'h0);

    rst_n = 1'b0; init = 1'b1; req = 1'b0; op = 4'h0; address = 32'h0; store_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    init  = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset asserted while the halfword store sits in WR.
    req = 1'b1; op = 4'b1001; address = 32'h10001012; store_data = 32'h0000BEEF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("rst_seq_rd", 32'(mem_read), 32'h1);
    @(negedge clk);
    check("rst_seq_wr", 32'(mem_write), 32'h1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ram_word4", ram[4], 32'h8001AB78);
    @(negedge clk);
    run_txn(mk(4'b0010, 32'h10001010, 32'h0, 1'b0, 2, 1, 0, 32'h8001AB78, 32'h0));

    // req held high: one sw per IDLE visit, 3-cycle period.
    req = 1'b1; op = 4'b1010; address = 32'h10001004; store_data = 32'h11223344;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("held_busy", 32'(busy), 32'((i % 3) != 2));
      check("held_write", 32'(mem_write), 32'((i % 3) == 0));
      check("held_done", 32'(done), 32'((i % 3) == 1));
      if ((i % 3) == 0) check("held_wdata", mem_write_data, 32'h11223344);
    end
    req = 1'b0;
    @(negedge clk);
    check("held_released", 32'(busy), 32'h0);
    run_txn(mk(4'b0010, 32'h10001004, 32'h0, 1'b0, 2, 1, 0, 32'h11223344, 32'h0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
